// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift/add-3 iteration per clock.
// The published result and overflow flag hold steady until the next conversion completes.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// SHIFT | one double-dabble iteration per clock, BIN_WIDTH iterations total
// DONE  | single cycle after bcd_out/ovf load; out_valid high
module bin_to_bcd_converter #(
    parameter int BIN_WIDTH   = 16,
    parameter int DIGITS      = 5,
    parameter int DISP_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic                  out_valid,
    output logic                  busy
);

    localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);
    localparam int ACC_W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                       state_q, state_d;
    logic [BIN_WIDTH-1:0]         shift_q, shift_next;
    logic [ACC_W-1:0]             acc_q, acc_adj, acc_next;
    logic [ACC_W+BIN_WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]             cnt_q;
    logic [ACC_W-1:0]             bcd_q;
    logic                         ovf_q;
    logic                         last_iter;

    // Any nonzero digit the display cannot show raises the overflow flag.
    function automatic logic high_nonzero(input logic [ACC_W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = DISP_DIGITS; i < DIGITS; i++) begin
            r = r | (|v[4*i +: 4]);
        end
        return r;
    endfunction

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        shifted    = {acc_adj, shift_q} << 1;
        acc_next   = shifted[ACC_W+BIN_WIDTH-1:BIN_WIDTH];
        shift_next = shifted[BIN_WIDTH-1:0];
    end

    assign last_iter = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q <= bin_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_next;
                    acc_q   <= acc_next;
                    cnt_q   <= cnt_q + 1'b1;
                    // Publish straight from the final iteration so DONE already shows the result.
                    if (last_iter) begin
                        bcd_q <= acc_next;
                        ovf_q <= high_nonzero(acc_next);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Scoreboard bench for bin_to_bcd_converter: the driver queues hand-computed results,
// and a monitor checks every out_valid pulse, its latency and output stability in between.
module tb_bin_to_bcd_converter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bin_in;
    logic [19:0] bcd_out;
    logic        ovf;
    logic        out_valid;
    logic        busy;

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
        int          hs;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [19:0] last_bcd = '0;
    logic        last_ovf = 1'b0;
    logic        prev_ov  = 1'b0;

    bin_to_bcd_converter #(.BIN_WIDTH(16), .DIGITS(5), .DISP_DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .bcd_out   (bcd_out),
        .ovf       (ovf),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per out_valid pulse; otherwise outputs must hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid) begin
                    chk("out_valid_one_cycle", 32'(prev_ov), 32'(0));
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
                        chk("ovf", 32'(ovf), 32'(e.ovf));
                        chk("latency", 32'(cyc), 32'(e.hs + 16));
                        chk("busy_in_done", 32'(busy), 32'(0));
                        last_bcd = e.bcd;
                        last_ovf = e.ovf;
                    end
                end else begin
                    chk("bcd_hold", 32'(bcd_out), 32'(last_bcd));
                    chk("ovf_hold", 32'(ovf), 32'(last_ovf));
                end
                prev_ov = out_valid;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("wait_ready_timeout", 32'(in_ready), 32'(1));
    endtask

    task automatic send(input logic [15:0] v, input logic [19:0] b, input logic o, output int hs);
        @(negedge clk);
        wait_ready();
        bin_in   = v;
        in_valid = 1'b1;
        hs       = cyc + 1;
        sb.push_back('{bcd: b, ovf: o, hs: hs});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("wait_done_timeout", 32'(sb.size()), 32'(0));
    endtask

    typedef struct {
        logic [15:0] v;
        logic [19:0] b;
        logic        o;
    } vec_t;

    vec_t vecs[5] = '{
        '{16'd0,     20'h00000, 1'b0},
        '{16'd1234,  20'h01234, 1'b0},
        '{16'd9999,  20'h09999, 1'b0},
        '{16'd10000, 20'h10000, 1'b1},
        '{16'hFFFF,  20'h65535, 1'b1}
    };

    initial begin
        int hs;
        int prev_hs;
        int n;
        rst      = 1'b0;
        in_valid = 1'b0;
        bin_in   = '0;
        repeat (3) @(negedge clk);
        chk("rst_bcd_out", 32'(bcd_out), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        rst = 1'b1;

        foreach (vecs[i]) begin
            send(vecs[i].v, vecs[i].b, vecs[i].o, hs);
            wait_done();
        end

        // Request arriving mid-conversion must be ignored.
        send(16'd42, 20'h00042, 1'b0, hs);
        n = 0;
        while (cyc != hs + 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        bin_in   = 16'd777;
        chk("ignored_req_in_ready", 32'(in_ready), 32'(0));
        chk("ignored_req_busy", 32'(busy), 32'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        wait_ready();
        chk("next_accept_cycle", 32'(cyc), 32'(hs + 17));

        // Reset mid-conversion aborts without publishing.
        send(16'd1234, 20'h01234, 1'b0, hs);
        wait_done();
        send(16'd5678, 20'h05678, 1'b0, hs);
        n = 0;
        while (cyc != hs + 7 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        last_bcd = '0;
        last_ovf = 1'b0;
        #1;
        chk("abort_bcd_out", 32'(bcd_out), 32'(0));
        chk("abort_ovf", 32'(ovf), 32'(0));
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        send(16'd5678, 20'h05678, 1'b0, hs);
        wait_done();

        // Back-to-back: in_valid held high, value steps 0..20.
        prev_hs = 0;
        @(negedge clk);
        for (int v = 0; v <= 20; v++) begin
            wait_ready();
            bin_in   = 16'(v);
            in_valid = 1'b1;
            hs       = cyc + 1;
            sb.push_back('{bcd: {12'h000, 4'(v / 10), 4'(v % 10)}, ovf: 1'b0, hs: hs});
            if (v > 0) chk("b2b_spacing", 32'(hs - prev_hs), 32'(18));
            prev_hs = hs;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_done();
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Sequential double-dabble converter between the CPU's register-5 debug tap and the seven-segment display driver.
- Takes an unsigned binary word and produces packed BCD digits, one nibble per decimal digit.
- The display then shows decimal instead of hex.
- Uses one shift/add-3 iteration per clock, so area stays small; results are held stable between conversions.

Parameters:
- BIN_WIDTH, 16, width of the binary input.
- DIGITS, 5, number of BCD digits produced; must satisfy 10^DIGITS > 2^BIN_WIDTH-1.
- DISP_DIGITS, 4, number of digits the display shows; drives the overflow flag.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  bin_in is valid and a conversion is requested.
- in_ready  output  1  converter can accept a request.
- bin_in  input  BIN_WIDTH  unsigned value to convert.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 in [3:0], most significant digit at the top.
- ovf  output  1  last result has a nonzero digit at index DISP_DIGITS or above.
- out_valid  output  1  one-cycle pulse: bcd_out/ovf just updated.
- busy  output  1  conversion in progress.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, bcd_out=0, ovf=0, out_valid=0, busy=0, in_ready=1, internal shift and BCD registers = 0, counter = 0.
- Reset asserted mid-conversion aborts it immediately. The partial result is never published.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - Handshake occurs when in_valid=1 at a rising edge.
  - On handshake: latch bin_in into the shift register, clear the BCD accumulator, clear the counter, go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge performs one iteration.
  - Step 1: every accumulator nibble >= 5 gets +3.
  - Step 2: the concatenation {accumulator, shift register} shifts left by 1, bringing the shift register MSB into accumulator bit 0.
  - The counter increments each iteration.
  - On the edge performing iteration number BIN_WIDTH (counter == BIN_WIDTH-1):
    - the post-iteration accumulator value is loaded directly into bcd_out;
    - ovf is computed from that same value and registered;
    - state goes to DONE.
- DONE:
  - Lasts exactly one cycle, with out_valid=1, busy=0, in_ready=0.
  - The next edge returns to IDLE with out_valid=0.
- Latency: if the handshake occurs at edge E, bcd_out is updated and out_valid rises at edge E+BIN_WIDTH. in_ready returns high at edge E+BIN_WIDTH+1.
- Maximum throughput: one conversion per BIN_WIDTH+2 cycles.
- in_valid while in_ready=0 is ignored. There is no queuing, and bin_in changes during a conversion have no effect.
- bcd_out and ovf change only on the DONE-entry edge or on reset. They hold their value indefinitely otherwise, so the display never flickers through intermediate values.
- Nibble adds are 4-bit with no carry out: a value of at most 9 plus 3 never exceeds 15.
- The accumulator is 4*DIGITS bits. No bits are lost for legal parameter values.
- bin_in=0 converts to all-zero digits; it is a normal conversion with the same latency.
- Maximum input (all ones): every digit must be correct. For defaults, 65535 gives 0x65535.

Test Plan:
- Reset held low, clk toggling -> bcd_out=0, ovf=0, out_valid=0, in_ready=1. Release and apply in_valid with bin_in=0 -> exactly 16 edges later out_valid pulses for one cycle, bcd_out=0x00000, ovf=0.
- bin_in=16'd1234 -> bcd_out=0x01234, ovf=0. Then bin_in=16'd9999 -> bcd_out=0x09999, ovf=0.
- bin_in=16'd10000 -> bcd_out=0x10000, ovf=1. Then bin_in=16'hFFFF -> bcd_out=0x65535, ovf=1.
- Start a conversion of 42, then pulse in_valid with bin_in=777 at edge E+5 -> in_ready=0 at that edge, request ignored, result 0x00042. A second request is accepted only at or after edge E+17.
- Convert 1234, then start 5678 and drive rst=0 at edge E+8 -> outputs clear immediately, no out_valid pulse. After release, a fresh 5678 request gives 0x05678.
- Back-to-back: in_valid held high continuously with bin_in stepping through 0..20 -> a new conversion starts every 18 cycles, and each published result equals the decimal value sampled at its handshake.
